// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: sizes, ALU opcodes and FSM state encoding.
package alu_sequencer_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int NUM_REGS     = 16;
  localparam int ADDR_WIDTH   = $clog2(NUM_REGS);
  localparam int OPCODE_WIDTH = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD          = 8'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBTRACT     = 8'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_MULTIPLY     = 8'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_EQUALS       = 8'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_GREATER_THAN = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic opcode_valid(input logic [OPCODE_WIDTH-1:0] op);
    return op <= OP_GREATER_THAN;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: one write port, two combinational operand reads,
// one registered host read. Contents clear on reset.
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH = NUM_REGS,
  parameter int WIDTH = DATA_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  input  logic [AW-1:0]    host_rd_addr,
  output logic [WIDTH-1:0] host_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Host read returns the pre-write contents when a write lands on the same edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      host_rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      host_rd_data <= mem[host_rd_addr];
    end
  end

  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];

endmodule

// File: rtl/alu_sequencer.sv
// Vector command sequencer: walks N elements through READ/EXEC/WRITE,
// driving an external combinational ALU and writing results back to the register file.
module alu_sequencer #(
  parameter int NUM_REGS   = alu_sequencer_pkg::NUM_REGS,
  parameter int DATA_WIDTH = alu_sequencer_pkg::DATA_WIDTH,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [7:0]            cmd_opcode_in,
  input  logic [AW-1:0]         cmd_src1_in,
  input  logic [AW-1:0]         cmd_src2_in,
  input  logic [AW-1:0]         cmd_dst_in,
  input  logic [AW-1:0]         cmd_length_in,
  input  logic                  host_wr_en_in,
  input  logic [AW-1:0]         host_wr_addr_in,
  input  logic [DATA_WIDTH-1:0] host_wr_data_in,
  input  logic [AW-1:0]         host_rd_addr_in,
  output logic [DATA_WIDTH-1:0] host_rd_data_out,
  output logic                  alu_enable_out,
  output logic [7:0]            alu_opcode_out,
  output logic [DATA_WIDTH-1:0] alu_input1_out,
  output logic [DATA_WIDTH-1:0] alu_input2_out,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);
  import alu_sequencer_pkg::*;

  state_t                state_reg, state_next;
  logic [7:0]            opcode_reg;
  logic [AW-1:0]         src1_reg, src2_reg, dst_reg, len_reg, idx_reg;
  logic [DATA_WIDTH-1:0] op1_reg, op2_reg, result_reg;
  logic                  error_reg;
  logic                  accept;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_data1, rd_data2;

  assign accept = cmd_valid_in & cmd_ready_out;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= '0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      op1_reg    <= '0;
      op2_reg    <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: if (accept) begin
          opcode_reg <= cmd_opcode_in;
          src1_reg   <= cmd_src1_in;
          src2_reg   <= cmd_src2_in;
          dst_reg    <= cmd_dst_in;
          len_reg    <= cmd_length_in;
          idx_reg    <= '0;
          error_reg  <= ~opcode_valid(cmd_opcode_in);
        end
        ST_READ: begin
          op1_reg <= rd_data1;
          op2_reg <= rd_data2;
        end
        ST_EXEC:  result_reg <= alu_result_in;
        ST_WRITE: if (idx_reg != len_reg) idx_reg <= idx_reg + 1'b1;
        default: ;
      endcase
    end
  end

  // Host writes share the single write port and are only granted while idle.
  always_comb begin
    state_next     = state_reg;
    cmd_ready_out  = 1'b0;
    busy_out       = 1'b1;
    done_out       = 1'b0;
    alu_enable_out = 1'b0;
    alu_opcode_out = '0;
    alu_input1_out = '0;
    alu_input2_out = '0;
    wr_en          = 1'b0;
    wr_addr        = host_wr_addr_in;
    wr_data        = host_wr_data_in;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready_out = 1'b1;
        busy_out      = 1'b0;
        wr_en         = host_wr_en_in;
        if (cmd_valid_in) state_next = opcode_valid(cmd_opcode_in) ? ST_READ : ST_DONE;
      end
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: begin
        alu_enable_out = 1'b1;
        alu_opcode_out = opcode_reg;
        alu_input1_out = op1_reg;
        alu_input2_out = op2_reg;
        state_next     = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        wr_addr    = dst_reg + idx_reg;
        wr_data    = result_reg;
        state_next = (idx_reg == len_reg) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done_out   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign error_out = error_reg;

  alu_regfile #(
    .DEPTH(NUM_REGS),
    .WIDTH(DATA_WIDTH),
    .AW   (AW)
  ) u_regfile (
    .clk         (clock_in),
    .srst        (reset_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr1    (src1_reg + idx_reg),
    .rd_data1    (rd_data1),
    .rd_addr2    (src2_reg + idx_reg),
    .rd_data2    (rd_data2),
    .host_rd_addr(host_rd_addr_in),
    .host_rd_data(host_rd_data_out)
  );

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NUM_REGS, 16, operand register file depth; address width 4.
REQ-002 Parameter DATA_WIDTH, 8, element and ALU operand width.
REQ-003 clock_in  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 cmd_valid_in  input  1  command offered.
REQ-006 cmd_ready_out  output  1  command accepted this cycle when high with cmd_valid_in.
REQ-007 cmd_opcode_in  input  8  ALU opcode: ADD=0, SUBTRACT=1, MULTIPLY=2, EQUALS=3, GREATER_THAN=4.
REQ-008 cmd_src1_in, cmd_src2_in, cmd_dst_in  input  4 each  base register addresses.
REQ-009 cmd_length_in  input  4  element count minus one (N = value+1, 1..16).
REQ-010 host_wr_en_in  input  1; host_wr_addr_in  input  4; host_wr_data_in  input  8  host register write.
REQ-011 host_rd_addr_in  input  4; host_rd_data_out  output  8  registered host read, 1-cycle latency.
REQ-012 alu_enable_out  output  1; alu_opcode_out  output  8; alu_input1_out, alu_input2_out  output  8  drive combinational ALU.
REQ-013 alu_result_in  input  8  combinational ALU result, same cycle.
REQ-014 busy_out  output  1  high in every non-IDLE state.
REQ-015 done_out  output  1  one-cycle completion pulse.
REQ-016 error_out  output  1  sticky: last command had opcode >4.

Function
REQ-017 FSM states: IDLE, READ, EXEC, WRITE, DONE.
REQ-018 cmd_ready_out = 1 only in IDLE; accept = cmd_valid_in & cmd_ready_out.
REQ-019 On accept: latch opcode, src1, src2, dst, N; clear element index i and error_out; valid opcode -> READ, opcode >4 -> DONE with error_out=1, no register writes.
REQ-020 READ: latch op1=rf[(src1+i) mod 16], op2=rf[(src2+i) mod 16] -> EXEC.
REQ-021 EXEC: alu_enable_out=1, alu_opcode_out=latched opcode, inputs=op1/op2; capture alu_result_in -> WRITE.
REQ-022 WRITE: rf[(dst+i) mod 16] <= captured result; i==N-1 -> DONE, else i+1 -> READ.
REQ-023 DONE: done_out=1 for exactly one cycle -> IDLE.
REQ-024 Outside EXEC: alu_enable_out=0, alu_opcode_out=0, alu_input1_out=0, alu_input2_out=0.
REQ-025 Latency: accept cycle = 0; element k written at end of cycle 3k+3; done_out in cycle 3N+1; invalid opcode done_out in cycle 1.
REQ-026 Address arithmetic wraps modulo 16; overlapping src/dst ranges use strictly sequential semantics (element k reads values written by elements <k).
REQ-027 Host writes honoured only in IDLE; ignored while busy_out=1.
REQ-028 Host write and accept in same IDLE cycle: host write lands first; command sees new value.
REQ-029 Host read allowed any cycle; returns register contents at the sampling edge.
REQ-030 cmd_valid_in while busy: not accepted, no side effects; sender holds command.

Reset
REQ-031 reset_in high at a rising edge: state=IDLE, i=0, all outputs 0 except cmd_ready_out=1 after release; busy_out=0, done_out=0, error_out=0.
REQ-032 Reset mid-command aborts immediately; no further register writes; no done_out.
REQ-033 Register file contents cleared to 0 on reset.

Structure
REQ-034 Shared package holds opcode localparams (ADD..GREATER_THAN), DATA_WIDTH, NUM_REGS, and FSM state enum typedef.
REQ-035 One sub-module: alu_regfile (16x8, one write port, three read ports: two operand, one host registered).
REQ-036 ALU is external; connected only through alu_* ports.

Verification
REQ-037 rf[0..3]={1,2,3,250}, rf[4..7]={10,20,30,10}; ADD src1=0 src2=4 dst=8 len=3 -> rf[8..11]={11,22,33,4}, done_out cycle 13.
REQ-038 rf[0]=16, rf[1]=16; MULTIPLY src1=0 src2=1 dst=2 len=0 -> rf[2]=0, done_out cycle 4.
REQ-039 rf[14,15,0,1]={5,5,9,1}, rf[2..5]={5,4,9,2}; GREATER_THAN src1=14 src2=2 dst=6 len=3 -> rf[6..9]={0,1,0,0}; EQUALS same -> {1,0,1,0}.
REQ-040 Opcode 7 -> error_out=1, done_out cycle 1, no rf change; next valid command clears error_out.
REQ-041 reset_in asserted cycle 5 of 4-element ADD -> busy_out=0 next cycle, no done_out, rf all 0.
REQ-042 cmd_valid_in held during busy with host_wr_en_in=1 -> second command accepted cycle after DONE; host writes during busy absent from rf.
